// File: rtl/maj_chain_seq_eval.sv
// Sequential MAJ3-chain evaluator: one programmed node per clock per vector.
// Optional complemented-edge operands when MAJ_COMPL_EN is defined.
module maj_chain_seq_eval #(
  parameter int NUM_IN    = 7,
  parameter int MAX_NODES = 16,
  parameter int SEL_W     = $clog2(NUM_IN + 1 + MAX_NODES),
  parameter int CNT_W     = $clog2(MAX_NODES + 1),
  localparam int AW       = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1,
`ifdef MAJ_COMPL_EN
  localparam int PW       = 3 * SEL_W + 3
`else
  localparam int PW       = 3 * SEL_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [PW-1:0]     prog_data,
  input  logic [CNT_W-1:0]  num_nodes,
  input  logic [NUM_IN-1:0] x,
  input  logic              start,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              out,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     k_q, k_d;
  logic [CNT_W-1:0]     n_q, n_d;
  logic [NUM_IN-1:0]    x_q, x_d;
  logic [MAX_NODES-1:0] w_q, w_d;
  logic [PW-1:0]        prog_q [MAX_NODES];
  logic [PW-1:0]        prog_d [MAX_NODES];
  logic                 out_q, out_d;
  logic                 err_q, err_d;
  logic                 acc_q, acc_d;
  logic                 done_q, done_d;

  logic [PW-1:0]        ins;
  logic [SEL_W-1:0]     sel;
  logic [2:0]           opv;
  logic                 op_err;
  logic                 maj;
  logic                 cnt_bad;

  // Operand fetch for the node currently addressed by k_q
  always_comb begin
    ins    = '0;
    sel    = '0;
    opv    = '0;
    op_err = 1'b0;
    for (int j = 0; j < MAX_NODES; j++) begin
      if (CNT_W'(j) == k_q) ins = prog_q[j];
    end
    for (int i = 0; i < 3; i++) begin
      sel = ins[i*SEL_W +: SEL_W];
      if (32'(sel) > NUM_IN + MAX_NODES) op_err = 1'b1;
      for (int b = 0; b < NUM_IN; b++) begin
        if (32'(sel) == b + 1) opv[i] = x_q[b];
      end
      for (int j = 0; j < MAX_NODES; j++) begin
        if (32'(sel) == NUM_IN + 1 + j) begin
          if (j < 32'(k_q)) opv[i] = w_q[j];
          else op_err = 1'b1;
        end
      end
`ifdef MAJ_COMPL_EN
      opv[i] = opv[i] ^ ins[3*SEL_W + i];
`endif
    end
    maj = (opv[0] & opv[1]) |
          (opv[0] & opv[2]) |
          (opv[1] & opv[2]);
  end

  assign cnt_bad = (num_nodes == '0) ||
                   (32'(num_nodes) > MAX_NODES);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    x_d     = x_q;
    w_d     = w_q;
    prog_d  = prog_q;
    out_d   = out_q;
    err_d   = err_q;
    acc_d   = acc_q;
    done_d  = 1'b0;

    // Program is frozen while a vector is in flight
    if (prog_we && state_q != S_EVAL &&
        32'(prog_addr) < MAX_NODES) begin
      prog_d[prog_addr] = prog_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d   = x;
          n_d   = num_nodes;
          k_d   = '0;
          acc_d = 1'b0;
          out_d = 1'b0;
          err_d = 1'b0;
          if (cnt_bad) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        for (int j = 0; j < MAX_NODES; j++) begin
          if (CNT_W'(j) == k_q) w_d[j] = maj;
        end
        acc_d = acc_q | op_err;
        k_d   = k_q + 1'b1;
        if (k_q == n_q - 1'b1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          out_d   = maj;
          err_d   = acc_q | op_err;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      x_q     <= '0;
      w_q     <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int j = 0; j < MAX_NODES; j++) begin
        prog_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      x_q     <= x_d;
      w_q     <= w_d;
      out_q   <= out_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      for (int j = 0; j < MAX_NODES; j++) begin
        prog_q[j] <= prog_d[j];
      end
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_EVAL);
  assign done  = done_q;
  assign out   = out_q;
  assign err   = err_q;

endmodule

// File: tb/tb_maj_chain_seq_eval.sv
// Bench for maj_chain_seq_eval: spec vectors, corner sequences, random programs.
// Honours MAJ_COMPL_EN the same way as the design.
module tb_maj_chain_seq_eval;

  localparam int NUM_IN    = 7;
  localparam int MAX_NODES = 16;
  localparam int SEL_W     = 5;
  localparam int CNT_W     = 5;
  localparam int AW        = 4;
`ifdef MAJ_COMPL_EN
  localparam int PW        = 3 * SEL_W + 3;
`else
  localparam int PW        = 3 * SEL_W;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [PW-1:0]     prog_data;
  logic [CNT_W-1:0]  num_nodes;
  logic [NUM_IN-1:0] x;
  logic              start;
  logic              ready, busy, done, out, err;

  maj_chain_seq_eval #(
    .NUM_IN   (NUM_IN),
    .MAX_NODES(MAX_NODES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .num_nodes(num_nodes),
    .x        (x),
    .start    (start),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] mprog [MAX_NODES];

  typedef struct {
    logic [NUM_IN-1:0] xv;
    int                n;
    int                eo;
    int                ee;
  } vec_t;

  vec_t tv [4];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack(input int s0, input int s1,
                                         input int s2, input int c);
    logic [PW-1:0] d;
    d = '0;
    d[0 +: SEL_W]       = SEL_W'(s0);
    d[SEL_W +: SEL_W]   = SEL_W'(s1);
    d[2*SEL_W +: SEL_W] = SEL_W'(s2);
`ifdef MAJ_COMPL_EN
    d[3*SEL_W +: 3]     = 3'(c);
`else
    if (c != 0) d = d;
`endif
    return d;
  endfunction

  // Reference: evaluate the node list directly from its rules
  function automatic void model(input logic [NUM_IN-1:0] xv, input int n,
                                output int o, output int e);
    int w [MAX_NODES];
    int s, v, ones, j;
    o = 0;
    e = 0;
    if (n == 0 || n > MAX_NODES) begin
      e = 1;
      return;
    end
    for (int k = 0; k < n; k++) begin
      ones = 0;
      for (int i = 0; i < 3; i++) begin
        s = int'(mprog[k][i*SEL_W +: SEL_W]);
        v = 0;
        if (s == 0) v = 0;
        else if (s <= NUM_IN) v = int'(xv[s-1]);
        else if (s <= NUM_IN + MAX_NODES) begin
          j = s - NUM_IN - 1;
          if (j < k) v = w[j];
          else e = 1;
        end else e = 1;
`ifdef MAJ_COMPL_EN
        if (mprog[k][3*SEL_W + i]) v = 1 - v;
`endif
        ones += v;
      end
      w[k] = (ones >= 2) ? 1 : 0;
    end
    o = w[n-1];
  endfunction

  task automatic wr(input int a, input int s0, input int s1,
                    input int s2, input int c);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = pack(s0, s1, s2, c);
    @(negedge clk);
    prog_we   = 1'b0;
    mprog[a]  = pack(s0, s1, s2, c);
  endtask

  task automatic load_spec_prog();
    wr(0, 1, 2, 7, 0);
    wr(1, 2, 6, 8, 0);
    wr(2, 1, 3, 8, 0);
    wr(3, 5, 9, 10, 0);
    wr(4, 3, 10, 11, 0);
    wr(5, 1, 6, 12, 0);
    wr(6, 4, 11, 13, 0);
  endtask

  task automatic run(input string tag, input logic [NUM_IN-1:0] xv,
                     input int n, input int eo, input int ee);
    int cyc, lat;
    @(negedge clk);
    chk({tag, " ready"}, ready, 1);
    start     = 1'b1;
    x         = xv;
    num_nodes = CNT_W'(n);
    @(negedge clk);
    start     = 1'b0;
    x         = NUM_IN'($urandom);
    num_nodes = CNT_W'($urandom);
    lat = (n == 0 || n > MAX_NODES) ? 1 : n + 1;
    chk({tag, " busy"}, busy, (lat > 1) ? 1 : 0);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, lat);
    chk({tag, " out"}, out, eo);
    chk({tag, " err"}, err, ee);
    @(negedge clk);
    chk({tag, " done_1cyc"}, done, 0);
    chk({tag, " out_held"}, out, eo);
  endtask

  task automatic run_model(input string tag, input logic [NUM_IN-1:0] xv,
                           input int n);
    int eo, ee;
    model(xv, n, eo, ee);
    run(tag, xv, n, eo, ee);
  endtask

  initial begin
    int cnt, cyc, s, n;
    rst       = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    num_nodes = '0;
    x         = '0;
    start     = 1'b0;
    for (int i = 0; i < MAX_NODES; i++) mprog[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst ready", ready, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst out", out, 0);
    chk("rst err", err, 0);

    tv[0] = '{7'b0001011, 7, 1, 0};
    tv[1] = '{7'b0001001, 7, 0, 0};
    tv[2] = '{7'h7F, 7, 1, 0};
    tv[3] = '{7'h00, 7, 0, 0};
    load_spec_prog();
    for (int i = 0; i < 4; i++) run($sformatf("vec%0d", i),
      tv[i].xv, tv[i].n, tv[i].eo, tv[i].ee);

    run("n0", 7'h7F, 0, 0, 1);
    run("n17", 7'h7F, 17, 0, 1);

    // start held through EVAL and DONE must not retrigger
    @(negedge clk);
    start = 1'b1; x = 7'b0001011; num_nodes = 5'd7;
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin x = '0; num_nodes = '0; end
      if (c == 8) start = 1'b0;
      if (done === 1'b1) cnt++;
    end
    chk("busy start dones", cnt, 1);
    chk("busy start out", out, 1);
    chk("busy start err", err, 0);

    // write during EVAL is dropped
    @(negedge clk);
    start = 1'b1; x = 7'b0001011; num_nodes = 5'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    prog_we = 1'b1; prog_addr = '0; prog_data = '0;
    @(negedge clk);
    prog_we = 1'b0;
    cyc = 3;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("evalwr latency", cyc, 8);
    chk("evalwr out", out, 1);
    run("evalwr next", 7'b0001011, 7, 1, 0);

    // write and start in the same cycle
    wr(0, 0, 0, 0, 0);
    run_model("zero n0", 7'b0001011, 7);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = '0; prog_data = pack(1, 2, 7, 0);
    start = 1'b1; x = 7'b0001011; num_nodes = 5'd7;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    mprog[0] = pack(1, 2, 7, 0);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("wrstart latency", cyc, 8);
    chk("wrstart out", out, 1);

    // forward reference
    wr(0, 9, 1, 2, 0);
    run("fwd x01", 7'b0000011, 1, 1, 1);
    run("fwd x1", 7'b0000010, 1, 0, 1);

    // reset in IDLE with a held result
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("idle rst out", out, 0);
    chk("idle rst err", err, 0);
    for (int i = 0; i < MAX_NODES; i++) mprog[i] = '0;
    run("cleared prog", 7'h7F, 1, 0, 0);

    // reset during EVAL aborts without done
    load_spec_prog();
    @(negedge clk);
    start = 1'b1; x = 7'h7F; num_nodes = 5'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst ready", ready, 1);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst out", out, 0);
    chk("midrst err", err, 0);
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    chk("midrst no done", cnt, 0);
    for (int i = 0; i < MAX_NODES; i++) mprog[i] = '0;

`ifdef MAJ_COMPL_EN
    wr(0, 1, 0, 0, 3'b110);
    run("compl x0", 7'b0000000, 1, 1, 0);
    run("compl x1", 7'b0000001, 1, 1, 0);
    wr(0, 1, 0, 0, 0);
    run("nocompl x1", 7'b0000001, 1, 0, 0);
`endif

    for (int p = 0; p < 15; p++) begin
      for (int k = 0; k < MAX_NODES; k++) begin
        int sv [3];
        for (int i = 0; i < 3; i++) begin
          if ($urandom_range(0, 9) == 0) s = $urandom_range(0, 31);
          else s = $urandom_range(0, NUM_IN + k);
          sv[i] = s;
        end
        wr(k, sv[0], sv[1], sv[2], $urandom_range(0, 7));
      end
      for (int v = 0; v < 3; v++) begin
        if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : 17;
        else n = $urandom_range(1, MAX_NODES);
        run_model($sformatf("rnd p%0d v%0d", p, v), NUM_IN'($urandom), n);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maj_chain_seq_eval.md
Name: maj_chain_seq_eval

Overview:
- Programmable, sequential evaluator for majority-of-3 (MAJ3) chains over NUM_IN primary inputs.
- Replaces fixed combinational majority networks: a node program (up to MAX_NODES MAJ3 nodes) is loaded once, then evaluated one node per clock per input vector.
- Used in the classification flow to sweep many functions on one datapath; output = last programmed node.

Parameters:
- NUM_IN, 7, primary input count (x vector width), 1..32
- MAX_NODES, 16, program memory depth (max MAJ3 nodes), 1..64
- SEL_W, $clog2(NUM_IN+1+MAX_NODES), operand selector width (derived, do not override)
- CNT_W, $clog2(MAX_NODES+1), node-count width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- prog_we  in  1  program write strobe
- prog_addr  in  $clog2(MAX_NODES)  node index to write
- prog_data  in  3*SEL_W (+3 with MAJ_COMPL_EN)  {[c2,c1,c0,] s2,s1,s0}, s0 in LSBs
- num_nodes  in  CNT_W  active node count, sampled at start
- x  in  NUM_IN  input vector, sampled at start
- start  in  1  evaluation request
- ready  out  1  high in IDLE; start accepted only when ready=1
- busy  out  1  high in EVAL
- done  out  1  one-cycle pulse, result valid
- out  out  1  value of node num_nodes-1; held until next accepted start
- err  out  1  program/config error for last evaluation; held with out

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; ready=1, busy=0, done=0, out=0, err=0; all program entries cleared to 0; node result register cleared. Applies mid-evaluation: evaluation aborted, no done.
- Selector decode: s=0 -> constant 0; 1..NUM_IN -> x[s-1]; NUM_IN+1..NUM_IN+MAX_NODES -> node w[s-NUM_IN-1]; larger -> 0 and err set.
- Node k computes w[k] = MAJ(op0,op1,op2) = op0&op1 | op0&op2 | op1&op2.
- Operand referring to node j>=k (forward/self reference): reads 0, err set.
- States: IDLE -> EVAL on start&ready; EVAL -> DONE after node num_nodes-1; DONE -> IDLE unconditionally (1 cycle, done=1).
- Timing: start sampled at cycle T (x, num_nodes latched, out/err cleared); node k evaluated in cycle T+1+k, result registered; done=1 in cycle T+num_nodes+1. Latency = num_nodes+1 cycles; throughput one vector per num_nodes+2 cycles.
- out updated to w[num_nodes-1] on DONE entry; stable until next accepted start.
- num_nodes=0 or >MAX_NODES: EVAL skipped; IDLE -> DONE next cycle, out=0, err=1.
- start while busy or in DONE: ignored (ready=0), no queuing.
- prog_we in IDLE/DONE: entry written at posedge. prog_we during EVAL: ignored (program must be stable). prog_we with start same cycle in IDLE: write takes effect, evaluation uses new entry.
- prog_addr >= MAX_NODES: write ignored.
- x and num_nodes changes after T have no effect on current evaluation.

Optional Feature:
- Macro MAJ_COMPL_EN.
- Defined: prog_data gains 3 MSB complement bits c2..c0; operand i inverted when ci=1 (complemented-edge MIG); complement of constant 0 yields 1; forward-reference operands read 0 before inversion.
- Undefined: prog_data is exactly 3*SEL_W bits; no inversion logic; plain monotone MAJ3 network.

Test Plan:
- Reset: assert rst 2 cycles mid-EVAL -> ready=1, busy=0, done=0, out=0, err=0, no done pulse afterwards.
- Load 7 nodes (s0,s1,s2): n0=(1,2,7), n1=(2,6,8), n2=(1,3,8), n3=(5,9,10), n4=(3,10,11), n5=(1,6,12), n6=(4,11,13); num_nodes=7; x=7'b0001011 (x0,x1,x3=1) -> done at T+8, out=1, err=0.
- Same program, x=7'b0001001 -> out=0; x=7'h7F -> out=1; x=7'h00 -> out=0; start pulsed during busy ignored, exactly one done per accepted start.
- Error cases: num_nodes=0 -> done at T+1, out=0, err=1; n0=(9,1,2) (forward ref), num_nodes=1 -> err=1, out=MAJ(0,x0,x1).
- Program write during EVAL at addr 0 -> ignored; next evaluation uses original entry and same result.
- MAJ_COMPL_EN defined: n0=(1,0,0) with c1=c2=1, num_nodes=1 -> out=1 for x0=0 and x0=1 (MAJ(x0,1,1)); c=0 -> out=0.
